// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1 UART receiver.
// A 2-FF synchronizer feeds a free-running tick divider and a five-state
// framing FSM. rx_int is a busy flag that rises once the start bit is
// confirmed at mid-bit and falls together with the rx_valid pulse (good
// frame) or the frame_err pulse (stop bit low).
module uart_rx_os #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600,
   parameter int OS     = 16,
   parameter int DIV    = CLK_HZ / (BAUD * OS)
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       uRx,
   output logic [7:0] rx_data,
   output logic       rx_int,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS - 1);
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OS / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             s_rx_q, s_rx_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_int_q, rx_int_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             tick;
   logic             start_edge;

   // Synchronizer next values: uRx is asynchronous, so it passes two flops
   // before any decision looks at it.
   always_comb begin
      sync1_d = uRx;
      s_rx_d  = sync1_q;
   end

   // Oversample tick divider. It is re-zeroed on the detected start edge so
   // that every later sample lands a fixed number of ticks from that edge.
   always_comb begin
      tick       = (div_cnt_q == DIV_LAST);
      start_edge = (state_q == S_IDLE) && !s_rx_q;
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
      if (start_edge) begin
         div_cnt_d = '0;
      end
   end

   // Framing FSM: next state, counters, shift register and output pulses.
   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_int_d    = rx_int_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            os_cnt_d = '0;
            if (!s_rx_q) begin
               state_d = S_START;
            end
         end

         // Re-check the line half a bit after the edge; a high sample means
         // the edge was a glitch and nothing is reported.
         S_START: begin
            if (tick) begin
               if (os_cnt_q == OS_MID) begin
                  os_cnt_d = '0;
                  if (!s_rx_q) begin
                     rx_int_d  = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = S_DATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         // One sample per bit, a full bit period after the previous one,
         // i.e. at the middle of each data bit. LSB arrives first.
         S_DATA: begin
            if (tick) begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d  = '0;
                  shift_d   = {s_rx_q, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         // Mid stop bit: commit the byte or flag a framing error. Leaving at
         // mid-bit gives half a bit of slack to catch a back-to-back start.
         S_STOP: begin
            if (tick) begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  rx_int_d = 1'b0;
                  if (s_rx_q) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_WAIT_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         // Break or stuck-low line: ignore everything until it returns high.
         S_WAIT_IDLE: begin
            if (s_rx_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         s_rx_q      <= 1'b1;
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_int_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         s_rx_q      <= s_rx_d;
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_int_q    <= rx_int_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_int    = rx_int_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frames at 64 clocks/bit with a scoreboard
// queue, plus a default-parameter smoke frame on a second instance.
module tb_uart_rx_os;

   localparam int BIT     = 64;   // 64 kHz clock, 1000 baud
   localparam int LAT_EXP = 610;  // 9.5 bits + 2 cycles
   localparam int LAT_TOL = 4;
   localparam int BIT2    = 5208; // 50 MHz / 9600
   localparam int LAT2    = 49476;

   logic       clk_in = 1'b0;
   logic       rst, uRx;
   logic [7:0] rx_data;
   logic       rx_int, rx_valid, frame_err;

   logic       rst2, uRx2;
   logic [7:0] rx_data2;
   logic       rx_int2, rx_valid2, frame_err2;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      bit         ferr;
      logic [7:0] data;
      int         t0;
   } exp_t;
   exp_t sb[$];

   uart_rx_os #(.CLK_HZ(64000), .BAUD(1000), .OS(16)) u_dut (
      .clk_in(clk_in), .rst(rst), .uRx(uRx), .rx_data(rx_data),
      .rx_int(rx_int), .rx_valid(rx_valid), .frame_err(frame_err)
   );

   uart_rx_os u_dut2 (
      .clk_in(clk_in), .rst(rst2), .uRx(uRx2), .rx_data(rx_data2),
      .rx_int(rx_int2), .rx_valid(rx_valid2), .frame_err(frame_err2)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic send_bit(input logic b);
      uRx = b;
      repeat (BIT) @(negedge clk_in);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input bit push);
      exp_t e;
      if (push) begin
         e.ferr = !stop;
         e.data = d;
         e.t0   = cyc;
         sb.push_back(e);
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      uRx = 1'b1;
      repeat (n) @(negedge clk_in);
   endtask

   // Watches for rx_int activity over n clocks while holding uRx.
   task automatic watch_int(input int n, output bit seen);
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk_in);
         if (rx_int) seen = 1'b1;
      end
   endtask

   // Monitor: pops an expectation whenever the DUT reports a frame.
   initial begin : monitor
      exp_t       e;
      logic [7:0] last_good;
      logic       int_prev;
      last_good = 8'h00;
      int_prev  = 1'b0;
      forever begin
         @(negedge clk_in);
         if (rst) begin
            last_good = 8'h00;
         end else if (rx_valid || frame_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1'b0, {rx_valid, frame_err}, 0);
            end else begin
               e = sb.pop_front();
               if (e.ferr) begin
                  chk("ferr_kind", frame_err && !rx_valid, {frame_err, rx_valid}, 2);
                  chk("ferr_data_held", rx_data == last_good, rx_data, last_good);
               end else begin
                  chk("valid_kind", rx_valid && !frame_err, {rx_valid, frame_err}, 2);
                  chk("rx_data", rx_data == e.data, rx_data, e.data);
                  last_good = e.data;
               end
               chk("latency", (cyc - e.t0 >= LAT_EXP - LAT_TOL) && (cyc - e.t0 <= LAT_EXP + LAT_TOL),
                   cyc - e.t0, LAT_EXP);
               chk("rx_int_fall", int_prev && !rx_int, {int_prev, rx_int}, 2);
            end
         end
         int_prev = rx_int;
      end
   end

   task automatic main_seq();
      bit seen;
      int n;
      rst = 1'b1;
      uRx = 1'b1;
      #2;
      chk("reset_rx_data", rx_data == 8'h00, rx_data, 0);
      chk("reset_rx_int", rx_int == 1'b0, rx_int, 0);
      chk("reset_rx_valid", rx_valid == 1'b0, rx_valid, 0);
      chk("reset_frame_err", frame_err == 1'b0, frame_err, 0);
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      idle(100);

      // Single byte with rx_int rise timing.
      fork
         send_frame(8'hA5, 1'b1, 1'b1);
         begin
            n = 0;
            while (!rx_int && n < 100) begin
               @(negedge clk_in);
               n++;
            end
            chk("rx_int_rise", n >= 33 && n <= 36, n, 34);
         end
      join
      idle(64);

      // Back-to-back, no idle gap.
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h55, 1'b1, 1'b1);
      idle(64);

      // Glitch rejection.
      uRx = 1'b0;
      repeat (20) @(negedge clk_in);
      uRx = 1'b1;
      watch_int(100, seen);
      chk("glitch_no_rx_int", !seen, seen, 0);
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(64);

      // Framing error followed by a long break.
      send_frame(8'h81, 1'b0, 1'b1);
      uRx = 1'b0;
      watch_int(2000, seen);
      chk("break_no_rx_int", !seen, seen, 0);
      idle(64);
      send_frame(8'h42, 1'b1, 1'b1);
      idle(64);

      // Reset during bit 4 of 0xC3 (LSB first: 1,1,0,0,0,0,1,1).
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      uRx = 1'b0;
      repeat (20) @(negedge clk_in);
      chk("pre_reset_rx_int", rx_int == 1'b1, rx_int, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_rx_int", rx_int == 1'b0, rx_int, 0);
      chk("midrst_rx_valid", rx_valid == 1'b0, rx_valid, 0);
      chk("midrst_frame_err", frame_err == 1'b0, frame_err, 0);
      chk("midrst_rx_data", rx_data == 8'h00, rx_data, 0);
      repeat (44) @(negedge clk_in);
      send_bit(1'b0);
      uRx = 1'b1;
      repeat (10) @(negedge clk_in);
      rst = 1'b0;
      watch_int(54 + 2 * BIT + 200, seen);
      chk("post_reset_quiet", !seen, seen, 0);
      send_frame(8'h7E, 1'b1, 1'b1);
      idle(100);
   endtask

   task automatic smoke();
      int t0, n;
      rst2 = 1'b1;
      uRx2 = 1'b1;
      repeat (3) @(negedge clk_in);
      rst2 = 1'b0;
      repeat (20) @(negedge clk_in);
      t0 = cyc;
      fork
         begin
            logic [9:0] fr;
            fr = {1'b1, 8'h5A, 1'b0};
            for (int i = 0; i < 10; i++) begin
               uRx2 = fr[i];
               repeat (BIT2) @(negedge clk_in);
            end
            uRx2 = 1'b1;
         end
         begin
            n = 0;
            while (!rx_valid2 && n < 60000) begin
               @(negedge clk_in);
               n++;
            end
            chk("smoke_latency", (cyc - t0 >= LAT2 - 326) && (cyc - t0 <= LAT2 + 326), cyc - t0, LAT2);
            chk("smoke_data", rx_valid2 && rx_data2 == 8'h5A, rx_data2, 8'h5A);
            chk("smoke_no_ferr", frame_err2 == 1'b0, frame_err2, 0);
         end
      join
   endtask

   initial begin
      fork
         main_seq();
         smoke();
      join
      repeat (10) @(negedge clk_in);
      chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
